decode_issue_stage: RTL and testbench

- Sits directly downstream of the fetch stage.
- Each cycle it consumes the fetched instruction pair (first_inst, second_inst, pc) and classifies each instruction to the even pipe or the odd pipe.
- It applies the dual-issue rules and drives registered even-pipe and odd-pipe issue slots to register fetch.
- When the pair cannot dual-issue, it splits the pair over two cycles and back-pressures fetch through stall_fetch.

---
 rtl/decode_issue_stage_pkg.sv | 72 +++++++
 rtl/decode_issue_stage_classifier.sv | 83 ++++++++
 rtl/decode_issue_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_decode_issue_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_issue_stage_pkg
// Purpose  : Shared types and constants for the decode/issue stage.
//            - pipe class and issue-state enumerations
//            - opcode table used by pipe_classifier
//            - register-field positions inside an instruction word
// Revision : 1.0 - initial release
// ============================================================================
package decode_issue_stage_pkg;

  // Pipe class of one instruction. STOP is a distinct class so the stage can
  // force a split and halt after it issues.
  typedef enum logic [1:0] {
    EVEN = 2'd0,
    ODD  = 2'd1,
    STOP = 2'd2
  } pipe_t;

  typedef enum logic [1:0] {
    PAIR   = 2'd0,
    SECOND = 2'd1,
    HALT   = 2'd2
  } issue_state_t;

  // Register fields. The architecture numbers bits big-endian (bit 0 = MSB):
  // RT = 25:31, RA = 18:24, RB = 11:17. Below are the little-endian indices.
  localparam int RT_LSB = 0;
  localparam int RT_MSB = 6;
  localparam int RA_LSB = 7;
  localparam int RA_MSB = 13;
  localparam int RB_LSB = 14;
  localparam int RB_MSB = 20;

  // 11-bit opcodes (RR / RI7 formats)
  localparam logic [10:0] OP_A    = 11'b00011000000;
  localparam logic [10:0] OP_SF   = 11'b00001000000;
  localparam logic [10:0] OP_AND  = 11'b00011000001;
  localparam logic [10:0] OP_OR   = 11'b00001000001;
  localparam logic [10:0] OP_XOR  = 11'b01001000001;
  localparam logic [10:0] OP_SHLI = 11'b00001111011;
  localparam logic [10:0] OP_NOP  = 11'b01000000001;
  localparam logic [10:0] OP_LNOP = 11'b00000000001;
  localparam logic [10:0] OP_STOP = 11'b00000000000;
  localparam logic [10:0] OP_LQX  = 11'b00111000100;
  localparam logic [10:0] OP_STQX = 11'b00101000100;
  localparam logic [10:0] OP_BI   = 11'b00110101000;

  // 9-bit opcodes (RI16 format)
  localparam logic [8:0] OP_IL  = 9'b010000001;
  localparam logic [8:0] OP_LQA = 9'b001100001;
  localparam logic [8:0] OP_BR  = 9'b001100100;

  // 8-bit opcodes (RI10 format)
  localparam logic [7:0] OP_LQD  = 8'b00110100;
  localparam logic [7:0] OP_STQD = 8'b00100100;
  localparam logic [7:0] OP_AI   = 8'b00011100;

  // 7-bit opcodes (RI18 format)
  localparam logic [6:0] OP_ILA  = 7'b0100001;
  localparam logic [6:0] OP_HBRA = 7'b0001000;

  // 4-bit opcodes (RRR format)
  localparam logic [3:0] OP_FMA = 4'b1110;

  // STOP travels through the odd slot; only EVEN uses the even slot.
  function automatic logic uses_odd_slot(input pipe_t p);
    return (p != EVEN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_issue_stage_classifier.sv
`default_nettype none
// ============================================================================
// Module   : pipe_classifier
// Purpose  : Combinational opcode decode to pipe class and RT-write flag.
// Ports    : inst_i      - instruction word
//            pipe_o      - EVEN / ODD / STOP
//            writes_rt_o - instruction writes its RT field
// Revision : 1.0 - initial release
// ============================================================================
module pipe_classifier
  import decode_issue_stage_pkg::*;
#(
  parameter int INST_W = 32
) (
  input  logic [INST_W-1:0] inst_i,
  output pipe_t             pipe_o,
  output logic              writes_rt_o
);

  logic [10:0] op11;
  logic [8:0]  op9;
  logic [7:0]  op8;
  logic [6:0]  op7;
  logic [3:0]  op4;
  logic        hit;
  logic        unused_fields;

  assign op11 = inst_i[INST_W-1 -: 11];
  assign op9  = inst_i[INST_W-1 -: 9];
  assign op8  = inst_i[INST_W-1 -: 8];
  assign op7  = inst_i[INST_W-1 -: 7];
  assign op4  = inst_i[INST_W-1 -: 4];

  assign unused_fields = ^inst_i[INST_W-12:0];

  // Longest opcode first so a long code is never shadowed by a shorter one.
  always_comb begin
    pipe_o      = EVEN;
    writes_rt_o = 1'b0;
    hit         = 1'b1;
    case (op11)
      OP_A, OP_SF, OP_AND, OP_OR, OP_XOR, OP_SHLI: writes_rt_o = 1'b1;
      OP_NOP:  pipe_o = EVEN;
      OP_LNOP: pipe_o = ODD;
      OP_STOP: pipe_o = STOP;
      OP_LQX:  begin pipe_o = ODD; writes_rt_o = 1'b1; end
      OP_STQX, OP_BI: pipe_o = ODD;
      default: hit = 1'b0;
    endcase
    if (!hit) begin
      hit = 1'b1;
      case (op9)
        OP_IL:  writes_rt_o = 1'b1;
        OP_LQA: begin pipe_o = ODD; writes_rt_o = 1'b1; end
        OP_BR:  pipe_o = ODD;
        default: hit = 1'b0;
      endcase
    end
    if (!hit) begin
      hit = 1'b1;
      case (op8)
        OP_LQD:  begin pipe_o = ODD; writes_rt_o = 1'b1; end
        OP_STQD: pipe_o = ODD;
        OP_AI:   writes_rt_o = 1'b1;
        default: hit = 1'b0;
      endcase
    end
    if (!hit) begin
      hit = 1'b1;
      case (op7)
        OP_ILA:  writes_rt_o = 1'b1;
        OP_HBRA: pipe_o = ODD;
        default: hit = 1'b0;
      endcase
    end
    if (!hit) begin
      // Anything still unmatched falls back to EVEN without an RT write.
      if (op4 == OP_FMA) writes_rt_o = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_issue_stage
// Purpose  : Classifies the fetched instruction pair, applies dual-issue
//            rules and drives registered even/odd issue slots. Pairs that
//            cannot dual-issue are split over two cycles with fetch stalled.
// Ports    : clock_i, reset_i (sync, active-high)
//            pc_input_i, first_inst_i, second_inst_i, fetch_valid_i - pair
//            stall_in_i (downstream hold), flush_i (redirect)
//            even_*_o / odd_*_o - registered issue slots
//            stall_fetch_o (combinational), halted_o
// Revision : 1.0 - initial release
// ============================================================================
module decode_issue_stage
  import decode_issue_stage_pkg::*;
#(
  parameter int INST_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int REG_IDX_W = 7
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] pc_input_i,
  input  logic [INST_W-1:0] first_inst_i,
  input  logic [INST_W-1:0] second_inst_i,
  input  logic              fetch_valid_i,
  input  logic              stall_in_i,
  input  logic              flush_i,
  output logic [INST_W-1:0] even_inst_o,
  output logic [ADDR_W-1:0] even_pc_o,
  output logic              even_valid_o,
  output logic [INST_W-1:0] odd_inst_o,
  output logic [ADDR_W-1:0] odd_pc_o,
  output logic              odd_valid_o,
  output logic              stall_fetch_o,
  output logic              halted_o
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  issue_state_t      state_q, state_d;
  logic [INST_W-1:0] even_inst_q, even_inst_d, odd_inst_q, odd_inst_d;
  logic [ADDR_W-1:0] even_pc_q, even_pc_d, odd_pc_q, odd_pc_d;
  logic              even_valid_q, even_valid_d, odd_valid_q, odd_valid_d;
  logic [INST_W-1:0] hold_inst_q, hold_inst_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
  pipe_t             hold_pipe_q, hold_pipe_d;
  logic              halted_q, halted_d;

  pipe_t                pipe0, pipe1;
  logic                 wr0, wr1;
  logic [REG_IDX_W-1:0] i0_rt, i1_ra, i1_rb;
  logic [ADDR_W-1:0]    pc_second;
  logic                 raw_hazard, split;
  logic                 unused_wr1;

  pipe_classifier #(.INST_W(INST_W)) u_cls0 (
    .inst_i      (first_inst_i),
    .pipe_o      (pipe0),
    .writes_rt_o (wr0)
  );

  pipe_classifier #(.INST_W(INST_W)) u_cls1 (
    .inst_i      (second_inst_i),
    .pipe_o      (pipe1),
    .writes_rt_o (wr1)
  );

  // I1 never feeds a later instruction inside the pair.
  assign unused_wr1 = wr1;

  assign i0_rt     = first_inst_i[RT_MSB:RT_LSB];
  assign i1_ra     = second_inst_i[RA_MSB:RA_LSB];
  assign i1_rb     = second_inst_i[RB_MSB:RB_LSB];
  assign pc_second = pc_input_i + PC_STEP;

  // RA/RB compared regardless of I1 format: a false hazard only costs a cycle.
  assign raw_hazard = wr0 && ((i1_ra == i0_rt) || (i1_rb == i0_rt));
  assign split      = (pipe0 == pipe1) || raw_hazard ||
                      (pipe0 == STOP) || (pipe1 == STOP);

  always_comb begin
    state_d       = state_q;
    even_inst_d   = even_inst_q;
    even_pc_d     = even_pc_q;
    even_valid_d  = even_valid_q;
    odd_inst_d    = odd_inst_q;
    odd_pc_d      = odd_pc_q;
    odd_valid_d   = odd_valid_q;
    hold_inst_d   = hold_inst_q;
    hold_pc_d     = hold_pc_q;
    hold_pipe_d   = hold_pipe_q;
    halted_d      = halted_q;
    stall_fetch_o = 1'b0;

    if (flush_i && (state_q != HALT)) begin
      even_valid_d = 1'b0;
      odd_valid_d  = 1'b0;
      state_d      = PAIR;
      hold_inst_d  = '0;
      hold_pc_d    = '0;
      hold_pipe_d  = EVEN;
    end else if (stall_in_i) begin
      stall_fetch_o = 1'b1;
    end else begin
      case (state_q)
        PAIR: begin
          even_valid_d = 1'b0;
          odd_valid_d  = 1'b0;
          if (fetch_valid_i) begin
            if (split) begin
              stall_fetch_o = 1'b1;
              if (uses_odd_slot(pipe0)) begin
                odd_inst_d  = first_inst_i;
                odd_pc_d    = pc_input_i;
                odd_valid_d = 1'b1;
              end else begin
                even_inst_d  = first_inst_i;
                even_pc_d    = pc_input_i;
                even_valid_d = 1'b1;
              end
              if (pipe0 == STOP) begin
                // I1 is dropped: nothing after a stop may issue.
                state_d  = HALT;
                halted_d = 1'b1;
              end else begin
                hold_inst_d = second_inst_i;
                hold_pc_d   = pc_second;
                hold_pipe_d = pipe1;
                state_d     = SECOND;
              end
            end else begin
              // No split implies exactly one EVEN and one ODD instruction.
              even_valid_d = 1'b1;
              odd_valid_d  = 1'b1;
              if (pipe0 == EVEN) begin
                even_inst_d = first_inst_i;
                even_pc_d   = pc_input_i;
                odd_inst_d  = second_inst_i;
                odd_pc_d    = pc_second;
              end else begin
                even_inst_d = second_inst_i;
                even_pc_d   = pc_second;
                odd_inst_d  = first_inst_i;
                odd_pc_d    = pc_input_i;
              end
            end
          end
        end

        SECOND: begin
          // Fetch still presents the same pair this cycle; it is ignored.
          even_valid_d = 1'b0;
          odd_valid_d  = 1'b0;
          if (uses_odd_slot(hold_pipe_q)) begin
            odd_inst_d  = hold_inst_q;
            odd_pc_d    = hold_pc_q;
            odd_valid_d = 1'b1;
          end else begin
            even_inst_d  = hold_inst_q;
            even_pc_d    = hold_pc_q;
            even_valid_d = 1'b1;
          end
          if (hold_pipe_q == STOP) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            state_d = PAIR;
          end
        end

        HALT: begin
          even_valid_d  = 1'b0;
          odd_valid_d   = 1'b0;
          stall_fetch_o = 1'b1;
        end

        default: state_d = PAIR;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= PAIR;
      even_inst_q  <= '0;
      even_pc_q    <= '0;
      even_valid_q <= 1'b0;
      odd_inst_q   <= '0;
      odd_pc_q     <= '0;
      odd_valid_q  <= 1'b0;
      hold_inst_q  <= '0;
      hold_pc_q    <= '0;
      hold_pipe_q  <= EVEN;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      even_inst_q  <= even_inst_d;
      even_pc_q    <= even_pc_d;
      even_valid_q <= even_valid_d;
      odd_inst_q   <= odd_inst_d;
      odd_pc_q     <= odd_pc_d;
      odd_valid_q  <= odd_valid_d;
      hold_inst_q  <= hold_inst_d;
      hold_pc_q    <= hold_pc_d;
      hold_pipe_q  <= hold_pipe_d;
      halted_q     <= halted_d;
    end
  end

  assign even_inst_o  = even_inst_q;
  assign even_pc_o    = even_pc_q;
  assign even_valid_o = even_valid_q;
  assign odd_inst_o   = odd_inst_q;
  assign odd_pc_o     = odd_pc_q;
  assign odd_valid_o  = odd_valid_q;
  assign halted_o     = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_issue_stage
// Purpose  : Directed self-checking bench for decode_issue_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_issue_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_input, first_inst, second_inst;
  logic        fetch_valid, stall_in, flush;
  logic [31:0] even_inst, even_pc, odd_inst, odd_pc;
  logic        even_valid, odd_valid, stall_fetch, halted;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  decode_issue_stage #(.INST_W(32), .ADDR_W(32), .REG_IDX_W(7)) dut (
    .clock_i       (clock),
    .reset_i       (reset),
    .pc_input_i    (pc_input),
    .first_inst_i  (first_inst),
    .second_inst_i (second_inst),
    .fetch_valid_i (fetch_valid),
    .stall_in_i    (stall_in),
    .flush_i       (flush),
    .even_inst_o   (even_inst),
    .even_pc_o     (even_pc),
    .even_valid_o  (even_valid),
    .odd_inst_o    (odd_inst),
    .odd_pc_o      (odd_pc),
    .odd_valid_o   (odd_valid),
    .stall_fetch_o (stall_fetch),
    .halted_o      (halted)
  );

  // Hand encodings: RR = op11|rb|ra|rt, RI10 = op8|i10|ra|rt
  localparam logic [31:0] A_3_1_2 = {11'b00011000000, 7'd2, 7'd1, 7'd3};
  localparam logic [31:0] A_4_1_2 = {11'b00011000000, 7'd2, 7'd1, 7'd4};
  localparam logic [31:0] LQD_5   = {8'b00110100, 10'd0, 7'd0, 7'd5};
  localparam logic [31:0] LQD_6R3 = {8'b00110100, 10'd0, 7'd3, 7'd6};
  localparam logic [31:0] LQD_7R1 = {8'b00110100, 10'd0, 7'd1, 7'd7};
  localparam logic [31:0] NOP_3   = {11'b01000000001, 7'd0, 7'd0, 7'd3};
  localparam logic [31:0] LNOP    = {11'b00000000001, 21'd0};
  localparam logic [31:0] STOPI   = 32'h0000_0000;
  localparam logic [31:0] UNKNOWN = 32'hFFFF_FFFF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pair(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1);
    pc_input    = pc;
    first_inst  = i0;
    second_inst = i1;
    fetch_valid = 1'b1;
    #1;
  endtask

  initial begin
    reset = 1'b1; pc_input = '0; first_inst = '0; second_inst = '0;
    fetch_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_even_valid", 32'(even_valid), 32'd0);
    chk("rst_odd_valid",  32'(odd_valid),  32'd0);
    chk("rst_halted",     32'(halted),     32'd0);
    chk("rst_even_inst",  even_inst,       32'd0);
    chk("rst_stall",      32'(stall_fetch), 32'd0);

    // Dual issue, even then odd
    pair(32'h00, A_3_1_2, LQD_5);
    chk("dual_stall", 32'(stall_fetch), 32'd0);
    tick();
    chk("dual_even_inst", even_inst, A_3_1_2);
    chk("dual_even_pc",   even_pc,   32'h00);
    chk("dual_odd_inst",  odd_inst,  LQD_5);
    chk("dual_odd_pc",    odd_pc,    32'h04);
    chk("dual_valids",    {30'd0, even_valid, odd_valid}, 32'd3);

    // Dual issue, odd then even
    pair(32'h08, LQD_5, A_3_1_2);
    chk("swap_stall", 32'(stall_fetch), 32'd0);
    tick();
    chk("swap_odd_pc",   odd_pc,    32'h08);
    chk("swap_even_pc",  even_pc,   32'h0C);
    chk("swap_even_inst", even_inst, A_3_1_2);
    chk("swap_valids",   {30'd0, even_valid, odd_valid}, 32'd3);

    // Structural split (both EVEN)
    pair(32'h10, A_3_1_2, A_4_1_2);
    chk("struct_stall0", 32'(stall_fetch), 32'd1);
    tick();
    chk("struct_c1_even_inst", even_inst, A_3_1_2);
    chk("struct_c1_even_pc",   even_pc,   32'h10);
    chk("struct_c1_valids",    {30'd0, even_valid, odd_valid}, 32'd2);
    chk("struct_c1_stall",     32'(stall_fetch), 32'd0);
    tick();
    chk("struct_c2_even_inst", even_inst, A_4_1_2);
    chk("struct_c2_even_pc",   even_pc,   32'h14);
    chk("struct_c2_valids",    {30'd0, even_valid, odd_valid}, 32'd2);

    // RAW split across different pipes
    pair(32'h20, A_3_1_2, LQD_6R3);
    chk("raw_stall0", 32'(stall_fetch), 32'd1);
    tick();
    chk("raw_c1_valids", {30'd0, even_valid, odd_valid}, 32'd2);
    chk("raw_c1_even_pc", even_pc, 32'h20);
    tick();
    chk("raw_c2_odd_inst", odd_inst, LQD_6R3);
    chk("raw_c2_odd_pc",   odd_pc,   32'h24);
    chk("raw_c2_valids",   {30'd0, even_valid, odd_valid}, 32'd1);

    // nop does not write RT, so no hazard
    pair(32'h30, NOP_3, LQD_6R3);
    chk("nop_stall", 32'(stall_fetch), 32'd0);
    tick();
    chk("nop_even_inst", even_inst, NOP_3);
    chk("nop_odd_pc",    odd_pc,    32'h34);
    chk("nop_valids",    {30'd0, even_valid, odd_valid}, 32'd3);

    // Odd-pipe split with PC wrap-around
    pair(32'hFFFF_FFFC, LQD_5, LQD_7R1);
    tick();
    chk("wrap_c1_odd_pc",  odd_pc, 32'hFFFF_FFFC);
    chk("wrap_c1_valids",  {30'd0, even_valid, odd_valid}, 32'd1);
    tick();
    chk("wrap_c2_odd_inst", odd_inst, LQD_7R1);
    chk("wrap_c2_odd_pc",   odd_pc,   32'h0000_0000);

    // Unknown opcode is EVEN: splits against an EVEN partner
    pair(32'h80, UNKNOWN, A_4_1_2);
    chk("unk_stall0", 32'(stall_fetch), 32'd1);
    tick();
    chk("unk_c1_even_inst", even_inst, UNKNOWN);
    tick();
    chk("unk_c2_even_pc", even_pc, 32'h84);

    // Flush during SECOND drops the held instruction
    pair(32'h40, A_3_1_2, A_4_1_2);
    tick();
    chk("flush_c1_even_pc", even_pc, 32'h40);
    flush = 1'b1;
    #1;
    chk("flush_stall", 32'(stall_fetch), 32'd0);
    tick();
    chk("flush_valids", {30'd0, even_valid, odd_valid}, 32'd0);
    flush = 1'b0; fetch_valid = 1'b0;
    tick();
    chk("flush_after_valids", {30'd0, even_valid, odd_valid}, 32'd0);
    pair(32'h50, A_3_1_2, LQD_5);
    chk("flush_pair_stall", 32'(stall_fetch), 32'd0);
    tick();
    chk("flush_pair_even_pc", even_pc, 32'h50);
    chk("flush_pair_valids",  {30'd0, even_valid, odd_valid}, 32'd3);

    // Downstream stall for 3 cycles freezes everything
    pair(32'h60, LQD_5, A_3_1_2);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_fetch_hi", 32'(stall_fetch), 32'd1);
      tick();
      chk("stall_even_pc", even_pc, 32'h50);
      chk("stall_odd_pc",  odd_pc,  32'h54);
      chk("stall_valids",  {30'd0, even_valid, odd_valid}, 32'd3);
    end
    stall_in = 1'b0;
    #1;
    chk("unstall_stall", 32'(stall_fetch), 32'd0);
    tick();
    chk("unstall_odd_pc",  odd_pc,  32'h60);
    chk("unstall_even_pc", even_pc, 32'h64);

    // Flush together with stall acts as flush
    flush = 1'b1; stall_in = 1'b1;
    #1;
    chk("flstall_stall", 32'(stall_fetch), 32'd0);
    tick();
    chk("flstall_valids", {30'd0, even_valid, odd_valid}, 32'd0);
    flush = 1'b0; stall_in = 1'b0;

    // Stop as I1: lnop, then stop, then permanent halt
    pair(32'h70, LNOP, STOPI);
    chk("stop_stall0", 32'(stall_fetch), 32'd1);
    tick();
    chk("stop_c1_odd_inst", odd_inst, LNOP);
    chk("stop_c1_odd_pc",   odd_pc,   32'h70);
    chk("stop_c1_valids",   {30'd0, even_valid, odd_valid}, 32'd1);
    chk("stop_c1_halted",   32'(halted), 32'd0);
    tick();
    chk("stop_c2_odd_inst", odd_inst, STOPI);
    chk("stop_c2_odd_pc",   odd_pc,   32'h74);
    chk("stop_c2_halted",   32'(halted), 32'd1);
    chk("stop_c2_stall",    32'(stall_fetch), 32'd1);
    tick();
    chk("halt_valids", {30'd0, even_valid, odd_valid}, 32'd0);
    chk("halt_stall",  32'(stall_fetch), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("halt_flush_halted", 32'(halted), 32'd1);
    chk("halt_flush_stall",  32'(stall_fetch), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; fetch_valid = 1'b0;
    #1;
    chk("rst2_halted", 32'(halted), 32'd0);
    chk("rst2_valids", {30'd0, even_valid, odd_valid}, 32'd0);
    chk("rst2_stall",  32'(stall_fetch), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
